// File: rtl/pipe_buf_stage.sv
// Generic pipeline buffer stage: two-entry skid buffer with valid/ready handshake,
// synchronous flush, and occupancy / saturating flush-drop statistics.
module pipe_buf_stage #(
  parameter int unsigned       DATA_W         = 64,
  parameter logic [DATA_W-1:0] RESET_VAL      = '0,
  parameter bit                CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned       CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic               in_xfer;
  logic               out_xfer;
  logic [2:0]         drop_inc;
  logic [CNT_W+1:0]   drop_sum;

  // Handshake outputs decode straight from the state register, so in_ready is registered.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
    case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign out_data = main_q;
  assign drop_cnt = drop_q;

  // Entries lost to a flush: everything held, minus one the consumer takes, plus one arriving.
  assign drop_inc = {1'b0, occupancy} - {2'b00, out_xfer} + {2'b00, in_xfer};
  assign drop_sum = {2'b00, drop_q} + {{(CNT_W-1){1'b0}}, drop_inc};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    drop_d  = drop_q;

    if (flush_i) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = RESET_VAL;
        skid_d = RESET_VAL;
      end
      if (drop_sum > {2'b00, CNT_MAX}) begin
        drop_d = CNT_MAX;
      end else begin
        drop_d = drop_sum[CNT_W-1:0];
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Self-checking bench for pipe_buf_stage: directed scenarios plus randomized traffic
// compared against a queue-based model of the two-entry buffer.
module tb_pipe_buf_stage;

  localparam int unsigned       DW   = 16;
  localparam logic [DW-1:0]     RV   = 16'hDEAD;
  localparam logic [DW-1:0]     RV2  = 16'h0055;
  localparam int                MAX1 = 65535;

  logic          clk;
  logic          reset_n;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   drop_cnt;

  logic          flush2;
  logic          in_valid2;
  logic          in_ready2;
  logic [DW-1:0] in_data2;
  logic          out_valid2;
  logic          out_ready2;
  logic [DW-1:0] out_data2;
  logic [1:0]    occupancy2;
  logic [1:0]    drop_cnt2;

  int checks;
  int errors;

  logic [DW-1:0] mq[$];
  int            m_drop;

  pipe_buf_stage #(
    .DATA_W(DW), .RESET_VAL(RV), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  pipe_buf_stage #(
    .DATA_W(DW), .RESET_VAL(RV2), .CLEAR_ON_FLUSH(1'b0), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .flush_i(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .occupancy(occupancy2), .drop_cnt(drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; the model follows the buffer's rules as a plain FIFO of depth 2.
  task automatic advance(input logic f, input logic iv, input logic [DW-1:0] d, input logic ordy);
    bit ix;
    bit ox;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    ix = iv && (mq.size() < 2);
    ox = (mq.size() > 0) && ordy;
    @(posedge clk);
    #1;
    if (f) begin
      m_drop = m_drop + mq.size() - int'(ox) + int'(ix);
      if (m_drop > MAX1) m_drop = MAX1;
      mq.delete();
    end else begin
      if (ox) void'(mq.pop_front());
      if (ix) mq.push_back(d);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    flush2 = 0; in_valid2 = 0; in_data2 = '0; out_ready2 = 0;
    mq.delete();
    m_drop = 0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 ||
        out_data !== RV || drop_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got v=%0b r=%0b occ=%0d data=%h drop=%0d, want v=0 r=1 occ=0 data=%h drop=0",
               out_valid, in_ready, occupancy, out_data, drop_cnt, RV);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      advance(1'b0, 1'b1, DW'(i), 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(i) || in_ready !== 1'b1 || occupancy !== 2'd1) begin
        errors++;
        $display("[TB] FAIL stream_%0d: got v=%0b data=%h r=%0b occ=%0d, want v=1 data=%h r=1 occ=1",
                 i, out_valid, out_data, in_ready, occupancy, DW'(i));
      end
    end
    advance(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("[TB] FAIL stream_drain: got v=%0b occ=%0d, want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    advance(1'b0, 1'b1, 16'h000A, 1'b0);
    advance(1'b0, 1'b1, 16'h000B, 1'b0);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h000A || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL skid_full: got occ=%0d r=%0b data=%h v=%0b, want occ=2 r=0 data=000a v=1",
               occupancy, in_ready, out_data, out_valid);
    end
    for (int k = 0; k < 3; k++) begin
      advance(1'b0, 1'b1, 16'h0BAD, 1'b0);
      checks++;
      if (out_data !== 16'h000A || occupancy !== 2'd2) begin
        errors++;
        $display("[TB] FAIL stall_hold: got data=%h occ=%0d, want data=000a occ=2", out_data, occupancy);
      end
    end
    advance(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_data !== 16'h000B || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      errors++;
      $display("[TB] FAIL skid_pop1: got data=%h r=%0b occ=%0d, want data=000b r=1 occ=1",
               out_data, in_ready, occupancy);
    end
    advance(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL skid_pop2: got v=%0b, want v=0", out_valid);
    end
  endtask

  task automatic test_flush_full();
    advance(1'b0, 1'b1, 16'h000A, 1'b0);
    advance(1'b0, 1'b1, 16'h000B, 1'b0);
    advance(1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== RV || drop_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL flush_full: got v=%0b occ=%0d data=%h drop=%0d, want v=0 occ=0 data=%h drop=2",
               out_valid, occupancy, out_data, drop_cnt, RV);
    end
  endtask

  task automatic test_flush_xfer();
    advance(1'b0, 1'b1, 16'h000C, 1'b0);
    advance(1'b1, 1'b1, 16'h000D, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || drop_cnt !== 16'd3 || out_data !== RV) begin
      errors++;
      $display("[TB] FAIL flush_xfer: got v=%0b r=%0b drop=%0d data=%h, want v=0 r=1 drop=3 data=%h",
               out_valid, in_ready, drop_cnt, out_data, RV);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      advance(($urandom_range(0, 9) == 0), $urandom_range(0, 1), DW'($urandom), ($urandom_range(0, 2) != 0));
      checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          occupancy !== 2'(mq.size()) || drop_cnt !== 16'(m_drop) ||
          (mq.size() > 0 && out_data !== mq[0])) begin
        errors++;
        $display("[TB] FAIL random_%0d: got v=%0b r=%0b occ=%0d drop=%0d data=%h, want occ=%0d drop=%0d head=%h",
                 n, out_valid, in_ready, occupancy, drop_cnt, out_data, mq.size(), m_drop,
                 (mq.size() > 0) ? mq[0] : RV);
      end
    end
  endtask

  task automatic test_reset_midstream();
    advance(1'b0, 1'b1, 16'h1111, 1'b0);
    advance(1'b0, 1'b1, 16'h2222, 1'b0);
    advance(1'b1, 1'b0, '0, 1'b0);
    advance(1'b0, 1'b1, 16'h3333, 1'b0);
    advance(1'b0, 1'b1, 16'h4444, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    m_drop = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 ||
        out_data !== RV || drop_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_midstream: got v=%0b r=%0b occ=%0d data=%h drop=%0d, want v=0 r=1 occ=0 data=%h drop=0",
               out_valid, in_ready, occupancy, out_data, drop_cnt, RV);
    end
    in_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    advance(1'b0, 1'b1, 16'h5555, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h5555 || occupancy !== 2'd1) begin
      errors++;
      $display("[TB] FAIL post_reset_load: got v=%0b data=%h occ=%0d, want v=1 data=5555 occ=1",
               out_valid, out_data, occupancy);
    end
  endtask

  // Narrow counter instance: each flush drops one entry, count must stick at 3.
  task automatic test_drop_saturation();
    logic [DW-1:0] d;
    int            exp_cnt;
    flush = 0; in_valid = 0; out_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      d = DW'($urandom);
      flush2 = 1'b0; in_valid2 = 1'b1; in_data2 = d; out_ready2 = 1'b0;
      @(posedge clk);
      #1;
      flush2 = 1'b1; in_valid2 = 1'b0;
      @(posedge clk);
      #1;
      flush2 = 1'b0;
      exp_cnt = (k < 3) ? k : 3;
      checks++;
      if (drop_cnt2 !== 2'(exp_cnt) || out_valid2 !== 1'b0 || out_data2 !== d) begin
        errors++;
        $display("[TB] FAIL sat_flush_%0d: got drop=%0d v=%0b data=%h, want drop=%0d v=0 data=%h",
                 k, drop_cnt2, out_valid2, out_data2, exp_cnt, d);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_flush_xfer();
    test_random();
    test_reset_midstream();
    test_drop_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_buf_stage.md
Name: pipe_buf_stage

Overview:
Generic, width-parametrised pipeline buffer stage, the successor to the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers.
- Carries any packed stage struct (flattened to DATA_W bits) with a valid/ready handshake.
- Contains a two-entry skid buffer, so upstream ready is registered and never combinationally depends on downstream ready.
- Adds synchronous flush for branch/jump squash, plus occupancy and flush-drop statistics.
- One instance sits between each pair of pipeline stages.

Parameters:
DATA_W, 64, width of the payload (the flattened stage struct).
RESET_VAL, 0, value loaded into both payload registers at reset; also loaded on flush when CLEAR_ON_FLUSH=1.
CLEAR_ON_FLUSH, 1, 1 = payload registers load RESET_VAL on flush (NOP bubble); 0 = payload registers hold their contents.
CNT_W, 16, width of the flush-drop counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
flush_i  input  1  synchronous squash of all buffered entries.
in_valid  input  1  upstream data valid.
in_ready  output  1  stage can accept; registered.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accepts.
out_data  output  DATA_W  payload; always driven from the main register.
occupancy  output  2  number of held entries: 0, 1 or 2.
drop_cnt  output  CNT_W  count of valid entries discarded by flushes; saturating.

Behaviour:
- Handshake definitions:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Both evaluated on the same clock edge.
- Storage: main register (drives out_data) and skid register.
- Reset (reset_n low, asynchronous) forces:
  - state=EMPTY; main=skid=RESET_VAL.
  - out_valid=0, in_ready=1, occupancy=0, drop_cnt=0.
  - Mid-transfer reset discards all entries.
  - First edge after deassertion behaves as EMPTY.
- Output decode: out_valid=(state!=EMPTY); in_ready=(state!=FULL); occupancy = EMPTY:0, ONE:1, FULL:2.
- FSM transitions when flush_i=0:
  - EMPTY: input transfer -> ONE, main<=in_data; otherwise stay.
  - ONE, input and output transfer -> ONE, main<=in_data.
  - ONE, input transfer only -> FULL, skid<=in_data, main unchanged.
  - ONE, output transfer only -> EMPTY.
  - ONE, neither -> hold.
  - FULL: in_ready=0, so no input transfer is possible. Output transfer -> ONE, main<=skid. Otherwise hold.
- Ordering: strict FIFO; the skid entry always leaves after the main entry.
- Latency: 1 cycle from input transfer to out_valid when the stage is EMPTY. Throughput: 1 transfer/cycle sustained when out_ready is held high.
- flush_i=1 (highest priority below reset):
  - Next state=EMPTY regardless of handshakes.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle counts as completed; the consumer has taken the data.
  - drop_cnt += (entries held) - (1 if output transfer), plus 1 if input transfer. Saturates at 2^CNT_W-1; never wraps.
  - If CLEAR_ON_FLUSH=1: main and skid <= RESET_VAL.
- Stall: out_ready=0 holds the main entry and out_data stable for any number of cycles. Upstream sees in_ready=0 only once both entries are full.
- out_data must not change while out_valid=1 and out_ready=0.

Test Plan:
- Reset/idle: assert reset_n=0 mid-stream with 2 entries held -> immediately out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL, drop_cnt=0.
- Streaming: out_ready=1 constantly; push 0x1..0x8 back-to-back -> out_data 0x1..0x8 in order, each 1 cycle after its input; in_ready stays 1; occupancy stays ≤1.
- Backpressure/skid: push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0 next cycle, out_data=0xA held. Raise out_ready -> 0xA then 0xB delivered; in_ready=1 after the first pop.
- Flush while FULL: hold 0xA, 0xB, out_ready=0, flush_i=1 -> next cycle EMPTY, out_valid=0, drop_cnt=2, out_data=RESET_VAL.
- Flush with simultaneous transfers: state ONE holding 0xC, out_ready=1, in_valid=1 with 0xD, flush_i=1 -> 0xC counted delivered; 0xD dropped; drop_cnt increments by 1; state EMPTY.
- Counter saturation: CNT_W=2; issue 5 single-entry flushes -> drop_cnt reaches 3 and stays 3.
